// File: rtl/ex_mem_pipe.sv
// EX/MEM interstage pipe: DEPTH elastic register stages with valid/ready
// flow control, flush, and a forwarding lookup over the in-flight stages.
// Stage 0 is the youngest; stage DEPTH-1 drives the MEM-side outputs.
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [RD_W-1:0]   out_rd,
    input  logic [RD_W-1:0]   fwd_rs,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_load_hazard
);

    // ctrl bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

    // Per-stage state
    logic              v_reg     [DEPTH];
    logic [3:0]        ctrl_reg  [DEPTH];
    logic [DATA_W-1:0] alu_reg   [DEPTH];
    logic [DATA_W-1:0] wdata_reg [DEPTH];
    logic [RD_W-1:0]   rd_reg    [DEPTH];

    // What each stage would load on advance: the previous stage, or the EX inputs
    logic              src_v     [DEPTH];
    logic [3:0]        src_ctrl  [DEPTH];
    logic [DATA_W-1:0] src_alu   [DEPTH];
    logic [DATA_W-1:0] src_wdata [DEPTH];
    logic [RD_W-1:0]   src_rd    [DEPTH];

    logic [DEPTH-1:0]  adv;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign src_v[gi]     = in_valid;
                assign src_ctrl[gi]  = in_ctrl;
                assign src_alu[gi]   = in_alu;
                assign src_wdata[gi] = in_wdata;
                assign src_rd[gi]    = in_rd;
            end else begin : g_body
                assign src_v[gi]     = v_reg[gi-1];
                assign src_ctrl[gi]  = ctrl_reg[gi-1];
                assign src_alu[gi]   = alu_reg[gi-1];
                assign src_wdata[gi] = wdata_reg[gi-1];
                assign src_rd[gi]    = rd_reg[gi-1];
            end
        end
    endgenerate

    // Advance chain: a stage may move when it is empty or the stage ahead moves,
    // which lets bubbles collapse under back-pressure.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !v_reg[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !v_reg[i] || adv[i+1];
        end
    end

    assign in_ready = adv[0];

    // Stage registers: reset clears everything, flush kills valid/ctrl but keeps
    // data, otherwise an advancing stage takes the payload only if it is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                v_reg[i]     <= 1'b0;
                ctrl_reg[i]  <= '0;
                alu_reg[i]   <= '0;
                wdata_reg[i] <= '0;
                rd_reg[i]    <= '0;
            end else if (flush) begin
                v_reg[i]    <= 1'b0;
                ctrl_reg[i] <= '0;
            end else if (adv[i]) begin
                v_reg[i] <= src_v[i];
                if (src_v[i]) begin
                    ctrl_reg[i]  <= src_ctrl[i];
                    alu_reg[i]   <= src_alu[i];
                    wdata_reg[i] <= src_wdata[i];
                    rd_reg[i]    <= src_rd[i];
                end else begin
                    ctrl_reg[i] <= '0;
                end
            end
        end
    end

    assign out_valid = v_reg[DEPTH-1];
    assign out_ctrl  = v_reg[DEPTH-1] ? ctrl_reg[DEPTH-1] : 4'b0000;
    assign out_alu   = alu_reg[DEPTH-1];
    assign out_wdata = wdata_reg[DEPTH-1];
    assign out_rd    = rd_reg[DEPTH-1];

    // Forwarding lookup: scan oldest to youngest so the youngest match wins;
    // a load winner cannot forward and raises the hazard instead.
    always_comb begin
        fwd_hit         = 1'b0;
        fwd_data        = '0;
        fwd_load_hazard = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v_reg[i] && ctrl_reg[i][CTRL_REGWRITE] &&
                (rd_reg[i] == fwd_rs) && (fwd_rs != '0)) begin
                if (ctrl_reg[i][CTRL_MEMTOREG]) begin
                    fwd_hit         = 1'b0;
                    fwd_data        = '0;
                    fwd_load_hazard = 1'b1;
                end else begin
                    fwd_hit         = 1'b1;
                    fwd_data        = alu_reg[i];
                    fwd_load_hazard = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a DEPTH=2 instance with a scoreboard on its
// output stream, plus a DEPTH=3 instance sharing the same inputs for flush.
module tb_ex_mem_pipe;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clock = 1'b0;
    logic          reset, in_valid, flush, out_ready;
    logic [3:0]    in_ctrl;
    logic [DW-1:0] in_alu, in_wdata;
    logic [RW-1:0] in_rd, fwd_rs;

    logic          a_in_ready, a_out_valid, a_fwd_hit, a_fwd_load_hazard;
    logic [3:0]    a_out_ctrl;
    logic [DW-1:0] a_out_alu, a_out_wdata, a_fwd_data;
    logic [RW-1:0] a_out_rd;

    logic          b_in_ready, b_out_valid, b_fwd_hit, b_fwd_load_hazard;
    logic [3:0]    b_out_ctrl;
    logic [DW-1:0] b_out_alu, b_out_wdata, b_fwd_data;
    logic [RW-1:0] b_out_rd;

    ex_mem_pipe #(.DATA_W(DW), .RD_W(RW), .DEPTH(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl),
        .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_alu(a_out_alu), .out_wdata(a_out_wdata), .out_rd(a_out_rd),
        .fwd_rs(fwd_rs), .fwd_hit(a_fwd_hit), .fwd_data(a_fwd_data),
        .fwd_load_hazard(a_fwd_load_hazard)
    );

    ex_mem_pipe #(.DATA_W(DW), .RD_W(RW), .DEPTH(3)) dut3 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl),
        .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_alu(b_out_alu), .out_wdata(b_out_wdata), .out_rd(b_out_rd),
        .fwd_rs(fwd_rs), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data),
        .fwd_load_hazard(b_fwd_load_hazard)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]    c;
        logic [DW-1:0] a;
        logic [DW-1:0] w;
        logic [RW-1:0] r;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] w, input logic [RW-1:0] r);
        in_valid = v;
        in_ctrl  = c;
        in_alu   = a;
        in_wdata = w;
        in_rd    = r;
    endtask

    // One clock: settle, score the DEPTH=2 handshakes, then cross the edge.
    task automatic tick();
        item_t e;
        #1;
        if (!reset && a_out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", a_out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                $display("xfer out rd=%0d ctrl=%h alu=%h wdata=%h", a_out_rd, a_out_ctrl, a_out_alu, a_out_wdata);
                chk("out_ctrl", a_out_ctrl, e.c);
                chk("out_alu", a_out_alu, e.a);
                chk("out_wdata", a_out_wdata, e.w);
                chk("out_rd", a_out_rd, e.r);
            end
        end
        if (!reset && !flush && in_valid && a_in_ready) begin
            sb.push_back({in_ctrl, in_alu, in_wdata, in_rd});
            $display("xfer in  rd=%0d ctrl=%h alu=%h", in_rd, in_ctrl, in_alu);
        end
        if (reset || flush) sb.delete();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Reset with live, non-zero inputs and no downstream consumer
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_rs = '0;
        drive(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
        tick();
        reset = 1'b0;
        drive(1'b0, 4'h0, '0, '0, '0);
        #1;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_ctrl", a_out_ctrl, 4'h0);
        chk("rst_out_alu", a_out_alu, 32'h0);
        chk("rst_out_wdata", a_out_wdata, 32'h0);
        chk("rst_out_rd", a_out_rd, 5'd0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_fwd_hit", a_fwd_hit, 1'b0);

        // Streaming: rd 1..4 back-to-back, visible on cycles 2..5
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1'b1, 4'(c + 1), 32'((c + 1) * 16), 32'hA000 + 32'(c), 5'(c + 1));
            else       drive(1'b0, 4'h0, '0, '0, '0);
            #1;
            chk("stream_out_valid", a_out_valid, (c >= 2 && c <= 5));
            tick();
        end

        // Back-pressure: three offered, two taken, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 32'h100, 32'hB0, 5'd10);
        #1; chk("bp_ready0", a_in_ready, 1'b1);
        tick();
        drive(1'b1, 4'h9, 32'h110, 32'hB1, 5'd11);
        #1; chk("bp_ready1", a_in_ready, 1'b1);
        tick();
        drive(1'b1, 4'h3, 32'h120, 32'hB2, 5'd12);
        #1; chk("bp_ready2", a_in_ready, 1'b0);
        tick();
        #1; chk("bp_ready3", a_in_ready, 1'b0);
        chk("bp_hold_rd", a_out_rd, 5'd10);
        tick();
        out_ready = 1'b1;
        #1; chk("bp_release_ready", a_in_ready, 1'b1);
        tick();
        drive(1'b0, 4'h0, '0, '0, '0);
        tick(); tick(); tick();
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_drained", a_out_valid, 1'b0);

        // Flush on the DEPTH=3 instance with all three stages full
        reset = 1'b1; tick(); reset = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'h1, 32'h200 + 32'(k), 32'hC0, 5'(20 + k));
            tick();
        end
        chk("fl_pre_valid", b_out_valid, 1'b1);
        chk("fl_pre_rd", b_out_rd, 5'd20);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 4'h1, 32'h2FF, 32'hCF, 5'd23);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'h0, '0, '0, '0);
        fwd_rs = 5'd21;
        #1;
        chk("fl_out_valid", b_out_valid, 1'b0);
        chk("fl_out_ctrl", b_out_ctrl, 4'h0);
        chk("fl_a_out_valid", a_out_valid, 1'b0);
        chk("fl_in_ready", b_in_ready, 1'b1);
        chk("fl_stale_fwd", b_fwd_hit, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_no_leak_valid", b_out_valid, 1'b0);
            chk("fl_no_leak_rd", b_out_rd, 5'd20);
        end

        // Forwarding on DEPTH=2: stage0 rd5/AA, stage1 rd5/BB
        reset = 1'b1; tick(); reset = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 32'hBB, 32'h0, 5'd5); tick();
        drive(1'b1, 4'h1, 32'hAA, 32'h0, 5'd5); tick();
        drive(1'b0, 4'h0, '0, '0, '0);
        fwd_rs = 5'd5; #1;
        chk("fwd_young_hit", a_fwd_hit, 1'b1);
        chk("fwd_young_data", a_fwd_data, 32'hAA);
        chk("fwd_young_haz", a_fwd_load_hazard, 1'b0);
        fwd_rs = 5'd0; #1;
        chk("fwd_x0_hit", a_fwd_hit, 1'b0);
        fwd_rs = 5'd6; #1;
        chk("fwd_miss_hit", a_fwd_hit, 1'b0);

        // Load into stage0 while BB is consumed; AA moves to stage1
        out_ready = 1'b1;
        drive(1'b1, 4'h7, 32'h77, 32'h0, 5'd7); tick();
        out_ready = 1'b0;
        drive(1'b0, 4'h0, '0, '0, '0);
        fwd_rs = 5'd7; #1;
        chk("ld_haz", a_fwd_load_hazard, 1'b1);
        chk("ld_hit", a_fwd_hit, 1'b0);
        fwd_rs = 5'd5; #1;
        chk("old_hit", a_fwd_hit, 1'b1);
        chk("old_data", a_fwd_data, 32'hAA);

        // Same entries invalidated by flush: data stays, matching stops
        flush = 1'b1; tick(); flush = 1'b0;
        fwd_rs = 5'd7; #1;
        chk("inv_haz", a_fwd_load_hazard, 1'b0);
        chk("inv_hit", a_fwd_hit, 1'b0);
        chk("inv_out_ctrl", a_out_ctrl, 4'h0);
        chk("inv_data_hold", a_out_alu, 32'hAA);

        // Reset wins over a simultaneous flush and clears the data fields
        reset = 1'b1; flush = 1'b1; tick(); reset = 1'b0; flush = 1'b0;
        #1;
        chk("rstfl_alu", a_out_alu, 32'h0);
        chk("rstfl_rd", a_out_rd, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
